// File: rtl/button_debouncer.sv
// button_debouncer
// Multi-channel push-button conditioner. Each channel passes its raw input
// through a two-flop synchronizer, then a small FSM with a stability counter
// accepts a new level only after it has been seen for STABLE_CYCLES
// consecutive synchronized samples. Shorter excursions are dropped silently.
//
// Parameters:
//   WIDTH          number of independent channels (>= 1)
//   STABLE_CYCLES  consecutive identical samples needed to accept a level (>= 2)
//
// Ports:
//   Clock      rising-edge clock for all state
//   Reset_n    asynchronous active-low reset
//   Button_in  raw asynchronous button levels, bit i = channel i
//   Level      debounced level per channel (registered)
//   Rise       one-cycle pulse when Level[i] goes 0->1 (registered)
//   Fall       one-cycle pulse when Level[i] goes 1->0 (registered)
module button_debouncer #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Button_in,
    output logic [WIDTH-1:0] Level,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    // The count at which the candidate level has been seen STABLE_CYCLES
    // times in a row: entering WAIT already accounts for the first sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    localparam logic [1:0] ST_STABLE_LO = 2'd0;
    localparam logic [1:0] ST_WAIT_HI   = 2'd1;
    localparam logic [1:0] ST_STABLE_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO   = 2'd3;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan

        logic             sync1;
        logic             sync2;
        logic [1:0]       state;
        logic [1:0]       state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             level_q;
        logic             level_next;
        logic             rise_q;
        logic             rise_next;
        logic             fall_q;
        logic             fall_next;

        // Next-state logic. Pulses default low and are raised only on the
        // cycle a WAIT state completes its count, so they last one clock.
        always_comb begin
            state_next = state;
            cnt_next   = cnt;
            level_next = level_q;
            rise_next  = 1'b0;
            fall_next  = 1'b0;
            case (state)
                ST_STABLE_LO: begin
                    if (sync2) begin
                        state_next = ST_WAIT_HI;
                        cnt_next   = CNT_ONE;
                    end else begin
                        cnt_next   = CNT_ZERO;
                    end
                end
                ST_WAIT_HI: begin
                    if (!sync2) begin
                        state_next = ST_STABLE_LO;
                        cnt_next   = CNT_ZERO;
                    end else if (cnt == CNT_LAST) begin
                        state_next = ST_STABLE_HI;
                        cnt_next   = CNT_ZERO;
                        level_next = 1'b1;
                        rise_next  = 1'b1;
                    end else begin
                        cnt_next   = cnt + CNT_ONE;
                    end
                end
                ST_STABLE_HI: begin
                    if (!sync2) begin
                        state_next = ST_WAIT_LO;
                        cnt_next   = CNT_ONE;
                    end else begin
                        cnt_next   = CNT_ZERO;
                    end
                end
                ST_WAIT_LO: begin
                    if (sync2) begin
                        state_next = ST_STABLE_HI;
                        cnt_next   = CNT_ZERO;
                    end else if (cnt == CNT_LAST) begin
                        state_next = ST_STABLE_LO;
                        cnt_next   = CNT_ZERO;
                        level_next = 1'b0;
                        fall_next  = 1'b1;
                    end else begin
                        cnt_next   = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_next = ST_STABLE_LO;
                    cnt_next   = CNT_ZERO;
                    level_next = 1'b0;
                end
            endcase
        end

        // Synchronizer and FSM registers. Reset discards any pending count,
        // so a channel always restarts from STABLE_LO.
        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
                sync1   <= 1'b0;
                sync2   <= 1'b0;
                state   <= ST_STABLE_LO;
                cnt     <= CNT_ZERO;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync1   <= Button_in[i];
                sync2   <= sync1;
                state   <= state_next;
                cnt     <= cnt_next;
                level_q <= level_next;
                rise_q  <= rise_next;
                fall_q  <= fall_next;
            end
        end

        assign Level[i] = level_q;
        assign Rise[i]  = rise_q;
        assign Fall[i]  = fall_q;
    end

endmodule
